// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, wrap pulse and optional saturation.
// Define MOD_UPDOWN_COUNTER_SAT_EN at compile time to hold at the bounds instead of wrapping.
module mod_updown_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZeroVal = '0;

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;
  logic             at_top, at_bottom;
  logic             load_in_range;
  logic [WIDTH-1:0] load_clamped;

  assign at_top    = (count_q == MaxVal);
  assign at_bottom = (count_q == ZeroVal);

  // Compare in 32 bits so MODULUS == 2**WIDTH does not truncate to zero.
  assign load_in_range = (32'(load_val) < MODULUS);
  assign load_clamped  = load_in_range ? load_val : MaxVal;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  logic sat_d, sat_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (rst) begin
      count_d = ZeroVal;
      sat_d   = 1'b0;
    end else if (load) begin
      count_d = load_clamped;
      sat_d   = 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          sat_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
          sat_d   = 1'b0;
        end
      end else begin
        if (at_bottom) begin
          sat_d = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
          sat_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    sat_q <= sat_d;
  end

  assign sat = sat_q;
`else
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (rst) begin
      count_d = ZeroVal;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          count_d = ZeroVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_bottom) begin
          count_d = MaxVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  assign sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomized plus directed scoreboard bench for mod_updown_counter (10-state and 2-state builds).
module tb_mod_updown_counter;

  typedef struct {
    int c;
    bit w;
    bit s;
  } st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit, modulus 10 instance
  logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0;
  logic [3:0] a_lv = '0;
  logic [3:0] a_count;
  logic       a_wrap, a_sat;

  // 1-bit, modulus 2 instance
  logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0;
  logic [0:0] b_lv = '0;
  logic [0:0] b_count;
  logic       b_wrap, b_sat;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
    .count(a_count), .wrap(a_wrap), .sat(a_sat)
  );

  mod_updown_counter #(.WIDTH(1), .MODULUS(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .count(b_count), .wrap(b_wrap), .sat(b_sat)
  );

  int checks = 0;
  int errors = 0;
  st_t qa[$];
  st_t qb[$];
  st_t ma, mb;

  // Reference: modular arithmetic on integers, bounds derived from the modulus.
  function automatic st_t next_st(int m, st_t cur, bit r, bit l, int lv, bit e, bit u);
    st_t n;
    int  tgt;
    n   = cur;
    n.w = 1'b0;
    if (r) begin
      n.c = 0;
      n.s = 1'b0;
    end else if (l) begin
      n.c = (lv < m) ? lv : m - 1;
      n.s = 1'b0;
    end else if (e) begin
      tgt = u ? cur.c + 1 : cur.c - 1;
      if (tgt >= 0 && tgt < m) begin
        n.c = tgt;
        n.s = 1'b0;
      end else begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
        n.s = 1'b1;
`else
        n.c = ((tgt % m) + m) % m;
        n.w = 1'b1;
`endif
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_a(input bit r, input bit l, input int lv, input bit e, input bit u);
    @(negedge clk);
    a_rst = r; a_load = l; a_lv = 4'(lv); a_en = e; a_up = u;
    @(posedge clk);
    ma = next_st(10, ma, r, l, lv, e, u);
    qa.push_back(ma);
  endtask

  task automatic step_b(input bit r, input bit l, input int lv, input bit e, input bit u);
    @(negedge clk);
    b_rst = r; b_load = l; b_lv = 1'(lv); b_en = e; b_up = u;
    @(posedge clk);
    mb = next_st(2, mb, r, l, lv, e, u);
    qb.push_back(mb);
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_rst = 1'b0; a_load = 1'b0; a_en = 1'b0;
  endtask

  always @(negedge clk) begin
    st_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_count", int'(a_count), e.c);
      chk("a_wrap", int'(a_wrap), int'(e.w));
      chk("a_sat", int'(a_sat), int'(e.s));
    end
  end

  always @(negedge clk) begin
    st_t e;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_count", int'(b_count), e.c);
      chk("b_wrap", int'(b_wrap), int'(e.w));
      chk("b_sat", int'(b_sat), int'(e.s));
    end
  end

  initial begin
    ma = '{c: 0, w: 1'b0, s: 1'b0};
    mb = '{c: 0, w: 1'b0, s: 1'b0};

    // Reset twice, then count up through the wrap
    repeat (2) step_a(1, 0, 0, 0, 0);
    repeat (12) step_a(0, 0, 0, 1, 1);
    // Load 3 and count down through zero
    step_a(0, 1, 3, 0, 0);
    repeat (5) step_a(0, 0, 0, 1, 0);
    // Out-of-range load clamps; load with reset loses to reset
    step_a(0, 1, 13, 1, 1);
    step_a(1, 1, 5, 1, 1);
    // Count to 6, alternate direction, then reset mid-sequence
    step_a(0, 1, 6, 0, 0);
    step_a(0, 0, 0, 1, 1);
    step_a(0, 0, 0, 1, 0);
    step_a(0, 0, 0, 1, 1);
    step_a(0, 0, 0, 1, 0);
    step_a(1, 0, 0, 1, 1);
    // First enabled down step after reset wraps to the top
    step_a(0, 0, 0, 1, 0);
    // Upper bound behaviour (saturates in the SAT build)
    step_a(0, 1, 8, 0, 0);
    repeat (3) step_a(0, 0, 0, 1, 1);
    step_a(0, 0, 0, 0, 1);
    step_a(0, 0, 0, 1, 0);
    // Lower bound, then a hold edge sitting at the bound
    step_a(0, 1, 0, 0, 0);
    step_a(0, 0, 0, 1, 0);
    step_a(0, 0, 0, 0, 0);
    step_a(0, 1, 15, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step_a($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
             int'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end
    idle_a();

    // 2-state instance: consecutive wraps
    step_b(1, 0, 0, 0, 0);
    repeat (4) step_b(0, 0, 0, 1, 1);
    repeat (3) step_b(0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      step_b($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 3, count register width in bits; legal range 1..16.
REQ-002 Parameter MODULUS, default 8, number of count states (0..MODULUS-1); legal range 2..2**WIDTH.
REQ-003 clk  input  1  rising-edge clock; all state changes on posedge clk only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; count advances one step per enabled edge.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement; sampled on the same edge as en.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  WIDTH  value written on load.
REQ-009 count  output  WIDTH  registered current count.
REQ-010 wrap  output  1  registered one-cycle pulse: the previous edge performed a wrap.
REQ-011 sat  output  1  registered level: count is held at a bound by saturation (see Configuration).

Function
REQ-012 Edge priority SHALL be rst > load > en; with none of these asserted, count holds.
REQ-013 On load: count <= load_val if load_val < MODULUS, else count <= MODULUS-1 (clamp); en and up ignored that edge.
REQ-014 On en && up: count < MODULUS-1 -> count+1; count == MODULUS-1 -> wrap to 0.
REQ-015 On en && !up: count > 0 -> count-1; count == 0 -> wrap to MODULUS-1.
REQ-016 Latency: count SHALL reflect an enabled step or load one edge after it is sampled; no combinational path from inputs to outputs.
REQ-017 wrap SHALL be 1 for exactly the cycle after each wrap edge and 0 otherwise; consecutive wraps (MODULUS=2) give wrap high on consecutive cycles.
REQ-018 wrap SHALL be 0 after any load edge or hold edge, even if count sits at a bound.
REQ-019 A direction change SHALL take effect on the edge where it is sampled; there is no pipeline flush or idle cycle.
REQ-020 Arithmetic SHALL be done in WIDTH bits; for MODULUS == 2**WIDTH, the natural roll-over SHALL match REQ-014/015 exactly.
REQ-021 count SHALL never hold a value >= MODULUS in any cycle after reset.

Reset
REQ-022 On rst high at a clock edge: count <= 0, wrap <= 0, sat <= 0, regardless of load/en.
REQ-023 rst asserted mid-count SHALL abort the sequence; the first enabled edge after rst deasserts produces 1 (up) or MODULUS-1 (down, wrap pulse asserted).
REQ-024 Before the first reset edge, outputs are undefined; the bench SHALL not check them.

Configuration
REQ-025 Macro MOD_UPDOWN_COUNTER_SAT_EN selects saturating mode at compile time.
REQ-026 With the macro defined: an enabled step past a bound holds count (at MODULUS-1 going up, at 0 going down); wrap stays 0; sat <= 1 on that edge.
REQ-027 With the macro defined: sat <= 0 on any edge that loads, resets, or moves count; sat holds its value on non-enabled hold edges.
REQ-028 Without the macro: wrap behaves as in REQ-014/015/017; sat is constant 0; the port list is identical in both builds.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-029 rst=1 for 2 edges, then en=1, up=1 for 12 edges -> count 1..9,0,1,2; wrap high only in the cycle after 9->0.
REQ-030 Load 3, then en=1, up=0 for 5 edges -> count 2,1,0,9,8; wrap high only in the cycle after 0->9.
REQ-031 load=1, load_val=13 with en=1 -> count=9, wrap=0; load and rst in the same edge -> count=0.
REQ-032 Count to 6, toggle up every edge with en=1 -> 7,6,7,6; then rst mid-sequence -> count=0 next cycle, wrap=0, sat=0.
REQ-033 Build with MOD_UPDOWN_COUNTER_SAT_EN: from 8 with up=1 for 3 edges -> 9,9,9 and sat=0,1,1, wrap=0; then up=0 for 1 edge -> 8, sat=0.
REQ-034 WIDTH=1, MODULUS=2, en=1, up=1 for 4 edges -> count 1,0,1,0; wrap high after each 1->0 edge.
